control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (T0-T2), execute (T3-T7) and HALT for a multi-cycle datapath.
// Build option ILLEGAL_TRAP_EN: opcodes 11001-11111 halt and raise a sticky illegal flag.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    input  logic        CON_FF,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        CONin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  ops,
    output logic        run,
    output logic        illegal
);

    typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
    typedef enum logic [3:0] {
        CL_ALU, CL_IMM, CL_MULDIV, CL_LD, CL_ST, CL_BR, CL_JR,
        CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILLEGAL
    } class_t;

    localparam int NCTL       = 25;
    localparam int C_GRA      = 0;
    localparam int C_GRB      = 1;
    localparam int C_GRC      = 2;
    localparam int C_RIN      = 3;
    localparam int C_ROUT     = 4;
    localparam int C_BAOUT    = 5;
    localparam int C_COUT     = 6;
    localparam int C_PCOUT    = 7;
    localparam int C_PCIN     = 8;
    localparam int C_INCPC    = 9;
    localparam int C_IRIN     = 10;
    localparam int C_MARIN    = 11;
    localparam int C_MDRIN    = 12;
    localparam int C_MDROUT   = 13;
    localparam int C_CONIN    = 14;
    localparam int C_YIN      = 15;
    localparam int C_ZIN      = 16;
    localparam int C_ZHIGHOUT = 17;
    localparam int C_ZLOWOUT  = 18;
    localparam int C_HIIN     = 19;
    localparam int C_LOIN     = 20;
    localparam int C_HIOUT    = 21;
    localparam int C_LOOUT    = 22;
    localparam int C_READ     = 23;
    localparam int C_WRITE    = 24;

    function automatic class_t classify(input logic [4:0] op);
        class_t c;
        if (op <= 5'd11) begin
            c = CL_ALU;
        end else if (op <= 5'd14) begin
            c = CL_IMM;
        end else if (op <= 5'd16) begin
            c = CL_MULDIV;
        end else begin
            case (op)
                5'd17:   c = CL_LD;
                5'd18:   c = CL_ST;
                5'd19:   c = CL_BR;
                5'd20:   c = CL_JR;
                5'd21:   c = CL_MFHI;
                5'd22:   c = CL_MFLO;
                5'd23:   c = CL_NOP;
                5'd24:   c = CL_HALT;
                default: c = CL_ILLEGAL;
            endcase
        end
        return c;
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic [4:0]        op_r;
    class_t            cls_s;
    class_t            fetch_cls_s;
    logic [NCTL-1:0]   ctl_s;
    logic [NCTL-1:0]   ctl_g_s;
    logic [4:0]        ops_s;
    logic              unused_ir_s;

    // T2 decides from the instruction being loaded; later steps use the latched opcode
    assign fetch_cls_s = classify(IR[31:27]);
    assign cls_s       = classify(op_r);
    assign unused_ir_s = ^IR[26:0];

    // State register and opcode latch
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r <= T0;
            op_r    <= 5'b00000;
        end else begin
            state_r <= next_state_s;
            if (state_r == T2) begin
                op_r <= IR[31:27];
            end else begin
                op_r <= op_r;
            end
        end
    end

    // Next-state selection
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            T0: next_state_s = T1;
            T1: begin
                if (mem_ready) next_state_s = T2;
                else           next_state_s = T1;
            end
            T2: begin
                case (fetch_cls_s)
                    CL_NOP:     next_state_s = T0;
                    CL_HALT:    next_state_s = HALT;
`ifdef ILLEGAL_TRAP_EN
                    CL_ILLEGAL: next_state_s = HALT;
`else
                    CL_ILLEGAL: next_state_s = T0;
`endif
                    default:    next_state_s = T3;
                endcase
            end
            T3: begin
                if (cls_s == CL_JR || cls_s == CL_MFHI || cls_s == CL_MFLO) next_state_s = T0;
                else                                                         next_state_s = T4;
            end
            T4: next_state_s = T5;
            T5: begin
                if (cls_s == CL_ALU || cls_s == CL_IMM) next_state_s = T0;
                else                                    next_state_s = T6;
            end
            T6: begin
                case (cls_s)
                    CL_LD: begin
                        if (mem_ready) next_state_s = T7;
                        else           next_state_s = T6;
                    end
                    CL_ST:   next_state_s = T7;
                    default: next_state_s = T0;
                endcase
            end
            T7: begin
                if (cls_s == CL_ST && !mem_ready) next_state_s = T7;
                else                              next_state_s = T0;
            end
            HALT:    next_state_s = HALT;
            default: next_state_s = T0;
        endcase
    end

    // Moore strobe decode from state and latched opcode
    always_comb begin
        ctl_s = {NCTL{1'b0}};
        ops_s = 5'b00000;
        case (state_r)
            T0: begin
                ctl_s[C_PCOUT] = 1'b1; ctl_s[C_MARIN] = 1'b1;
                ctl_s[C_INCPC] = 1'b1; ctl_s[C_ZIN]   = 1'b1;
            end
            T1: begin
                ctl_s[C_ZLOWOUT] = 1'b1; ctl_s[C_PCIN]  = 1'b1;
                ctl_s[C_READ]    = 1'b1; ctl_s[C_MDRIN] = 1'b1;
            end
            T2: begin
                ctl_s[C_MDROUT] = 1'b1; ctl_s[C_IRIN] = 1'b1;
            end
            T3: begin
                case (cls_s)
                    CL_ALU, CL_IMM: begin ctl_s[C_GRB] = 1'b1; ctl_s[C_ROUT] = 1'b1;  ctl_s[C_YIN] = 1'b1;   end
                    CL_MULDIV:      begin ctl_s[C_GRA] = 1'b1; ctl_s[C_ROUT] = 1'b1;  ctl_s[C_YIN] = 1'b1;   end
                    CL_LD, CL_ST:   begin ctl_s[C_GRB] = 1'b1; ctl_s[C_BAOUT] = 1'b1; ctl_s[C_YIN] = 1'b1;   end
                    CL_BR:          begin ctl_s[C_GRA] = 1'b1; ctl_s[C_ROUT] = 1'b1;  ctl_s[C_CONIN] = 1'b1; end
                    CL_JR:          begin ctl_s[C_GRA] = 1'b1; ctl_s[C_ROUT] = 1'b1;  ctl_s[C_PCIN] = 1'b1;  end
                    CL_MFHI:        begin ctl_s[C_HIOUT] = 1'b1; ctl_s[C_GRA] = 1'b1; ctl_s[C_RIN] = 1'b1;   end
                    CL_MFLO:        begin ctl_s[C_LOOUT] = 1'b1; ctl_s[C_GRA] = 1'b1; ctl_s[C_RIN] = 1'b1;   end
                    default:        ctl_s = {NCTL{1'b0}};
                endcase
            end
            T4: begin
                case (cls_s)
                    CL_ALU: begin
                        ctl_s[C_GRC] = 1'b1; ctl_s[C_ROUT] = 1'b1; ctl_s[C_ZIN] = 1'b1;
                        ops_s = op_r;
                    end
                    CL_IMM: begin
                        ctl_s[C_COUT] = 1'b1; ctl_s[C_ZIN] = 1'b1;
                        // addi adds, andi/ori map onto the and/or ALU codes
                        case (op_r)
                            5'd13:   ops_s = 5'b00010;
                            5'd14:   ops_s = 5'b00011;
                            default: ops_s = 5'b00000;
                        endcase
                    end
                    CL_MULDIV: begin
                        ctl_s[C_GRB] = 1'b1; ctl_s[C_ROUT] = 1'b1; ctl_s[C_ZIN] = 1'b1;
                        ops_s = op_r;
                    end
                    CL_LD, CL_ST: begin ctl_s[C_COUT] = 1'b1; ctl_s[C_ZIN] = 1'b1; end
                    CL_BR:        begin ctl_s[C_PCOUT] = 1'b1; ctl_s[C_YIN] = 1'b1; end
                    default:      ctl_s = {NCTL{1'b0}};
                endcase
            end
            T5: begin
                case (cls_s)
                    CL_ALU, CL_IMM: begin ctl_s[C_ZLOWOUT] = 1'b1; ctl_s[C_GRA] = 1'b1; ctl_s[C_RIN] = 1'b1; end
                    CL_MULDIV:      begin ctl_s[C_ZLOWOUT] = 1'b1; ctl_s[C_LOIN] = 1'b1;  end
                    CL_LD, CL_ST:   begin ctl_s[C_ZLOWOUT] = 1'b1; ctl_s[C_MARIN] = 1'b1; end
                    CL_BR:          begin ctl_s[C_COUT] = 1'b1; ctl_s[C_ZIN] = 1'b1;      end
                    default:        ctl_s = {NCTL{1'b0}};
                endcase
            end
            T6: begin
                case (cls_s)
                    CL_MULDIV: begin ctl_s[C_ZHIGHOUT] = 1'b1; ctl_s[C_HIIN] = 1'b1; end
                    CL_LD:     begin ctl_s[C_READ] = 1'b1; ctl_s[C_MDRIN] = 1'b1; end
                    CL_ST:     begin ctl_s[C_GRA] = 1'b1; ctl_s[C_ROUT] = 1'b1; ctl_s[C_MDRIN] = 1'b1; end
                    CL_BR: begin
                        if (CON_FF) begin
                            ctl_s[C_ZLOWOUT] = 1'b1; ctl_s[C_PCIN] = 1'b1;
                        end else begin
                            ctl_s[C_PCIN] = 1'b0;
                        end
                    end
                    default: ctl_s = {NCTL{1'b0}};
                endcase
            end
            T7: begin
                case (cls_s)
                    CL_LD:   begin ctl_s[C_MDROUT] = 1'b1; ctl_s[C_GRA] = 1'b1; ctl_s[C_RIN] = 1'b1; end
                    CL_ST:   ctl_s[C_WRITE] = 1'b1;
                    default: ctl_s = {NCTL{1'b0}};
                endcase
            end
            default: ctl_s = {NCTL{1'b0}};
        endcase
    end

    // clear silences every strobe at once, not just at the next edge
    assign ctl_g_s = clear ? ctl_s : {NCTL{1'b0}};
    assign ops     = clear ? ops_s : 5'b00000;
    assign run     = clear & (state_r != HALT);

`ifdef ILLEGAL_TRAP_EN
    logic illegal_r;

    // Sticky flag set by the fetch that traps an undefined opcode
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            illegal_r <= 1'b0;
        end else if (state_r == T2 && fetch_cls_s == CL_ILLEGAL) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end
    assign illegal = illegal_r;
`else
    assign illegal = 1'b0;
`endif

    assign Gra      = ctl_g_s[C_GRA];
    assign Grb      = ctl_g_s[C_GRB];
    assign Grc      = ctl_g_s[C_GRC];
    assign Rin      = ctl_g_s[C_RIN];
    assign Rout     = ctl_g_s[C_ROUT];
    assign BAout    = ctl_g_s[C_BAOUT];
    assign Cout     = ctl_g_s[C_COUT];
    assign PCout    = ctl_g_s[C_PCOUT];
    assign PCin     = ctl_g_s[C_PCIN];
    assign IncPC    = ctl_g_s[C_INCPC];
    assign IRin     = ctl_g_s[C_IRIN];
    assign MARin    = ctl_g_s[C_MARIN];
    assign MDRin    = ctl_g_s[C_MDRIN];
    assign MDRout   = ctl_g_s[C_MDROUT];
    assign CONin    = ctl_g_s[C_CONIN];
    assign Yin      = ctl_g_s[C_YIN];
    assign Zin      = ctl_g_s[C_ZIN];
    assign Zhighout = ctl_g_s[C_ZHIGHOUT];
    assign Zlowout  = ctl_g_s[C_ZLOWOUT];
    assign HIin     = ctl_g_s[C_HIIN];
    assign LOin     = ctl_g_s[C_LOIN];
    assign HIout    = ctl_g_s[C_HIOUT];
    assign LOout    = ctl_g_s[C_LOOUT];
    assign Read     = ctl_g_s[C_READ];
    assign Write    = ctl_g_s[C_WRITE];

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-level plan of expected strobe sets per cycle,
// random opcodes/memory latencies, plus directed fetch, add, reset-during-write checks.
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic [31:0] IR;
    logic        mem_ready;
    logic        CON_FF;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, IRin, MARin;
    logic MDRin, MDRout, CONin, Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout;
    logic Read, Write, run, illegal;
    logic [4:0] ops;

    control_sequencer dut (
        .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready), .CON_FF(CON_FF),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .CONin(CONin), .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout),
        .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
        .Read(Read), .Write(Write), .ops(ops), .run(run), .illegal(illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    string names [25] = '{"Gra", "Grb", "Grc", "Rin", "Rout", "BAout", "Cout", "PCout", "PCin",
                          "IncPC", "IRin", "MARin", "MDRin", "MDRout", "CONin", "Yin", "Zin",
                          "Zhighout", "Zlowout", "HIin", "LOin", "HIout", "LOout", "Read", "Write"};

    typedef struct {
        logic [24:0] ctl;
        logic [4:0]  ops;
        logic        mr;
        logic        run;
        logic        ill;
        logic [31:0] ir;
        logic        con;
    } ent_t;

    ent_t        q[$];
    ent_t        cur;
    logic        chk_en;
    int          n_chk;
    int          n_pass;
    logic [31:0] plan_ir;
    logic        plan_con;
    logic        halt_pend;
    logic        trap_pend;
    int          irin_cnt;

`ifdef ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    function automatic logic [24:0] pack_dut();
        return {Write, Read, LOout, HIout, LOin, HIin, Zlowout, Zhighout, Zin, Yin, CONin,
                MDRout, MDRin, MARin, IRin, IncPC, PCin, PCout, Cout, BAout, Rout, Rin,
                Grc, Grb, Gra};
    endfunction

    function automatic logic [24:0] bit_of(input string w);
        logic [24:0] v;
        v = 25'd0;
        for (int j = 0; j < 25; j++) begin
            if (names[j] == w) v[j] = 1'b1;
        end
        if (v == 25'd0) $fatal(1, "model: unknown strobe name %s", w);
        return v;
    endfunction

    // Strobe set written as a space-separated list of port names
    function automatic logic [24:0] sig(input string s);
        logic [24:0] v;
        string w;
        v = 25'd0;
        w = "";
        for (int i = 0; i <= s.len(); i++) begin
            if (i == s.len() || s.substr(i, i) == " ") begin
                if (w.len() > 0) v = v | bit_of(w);
                w = "";
            end else begin
                w = {w, s.substr(i, i)};
            end
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic push_ex(input string s, input logic [4:0] o, input logic mr,
                           input logic rn, input logic il);
        ent_t e;
        e.ctl = sig(s); e.ops = o; e.mr = mr; e.run = rn; e.ill = il;
        e.ir = plan_ir; e.con = plan_con;
        q.push_back(e);
    endtask

    task automatic push(input string s, input logic [4:0] o, input logic mr);
        push_ex(s, o, mr, 1'b1, 1'b0);
    endtask

    // One instruction as the cycle-by-cycle list of strobe sets it must produce
    task automatic plan(input logic [4:0] op, input logic con, input int w1, input int w6, input int w7);
        plan_ir  = {op, 27'($urandom)};
        plan_con = con;
        push("PCout MARin IncPC Zin", 5'd0, 1'($urandom));
        repeat (w1) push("Zlowout PCin Read MDRin", 5'd0, 1'b0);
        push("Zlowout PCin Read MDRin", 5'd0, 1'b1);
        push("MDRout IRin", 5'd0, 1'($urandom));
        if (op <= 5'd14) begin
            push("Grb Rout Yin", 5'd0, 1'($urandom));
            if (op <= 5'd11)      push("Grc Rout Zin", op, 1'($urandom));
            else if (op == 5'd12) push("Cout Zin", 5'd0, 1'($urandom));
            else if (op == 5'd13) push("Cout Zin", 5'd2, 1'($urandom));
            else                  push("Cout Zin", 5'd3, 1'($urandom));
            push("Zlowout Gra Rin", 5'd0, 1'($urandom));
        end else if (op == 5'd15 || op == 5'd16) begin
            push("Gra Rout Yin", 5'd0, 1'($urandom));
            push("Grb Rout Zin", op, 1'($urandom));
            push("Zlowout LOin", 5'd0, 1'($urandom));
            push("Zhighout HIin", 5'd0, 1'($urandom));
        end else if (op == 5'd17 || op == 5'd18) begin
            push("Grb BAout Yin", 5'd0, 1'($urandom));
            push("Cout Zin", 5'd0, 1'($urandom));
            push("Zlowout MARin", 5'd0, 1'($urandom));
            if (op == 5'd17) begin
                repeat (w6) push("Read MDRin", 5'd0, 1'b0);
                push("Read MDRin", 5'd0, 1'b1);
                push("MDRout Gra Rin", 5'd0, 1'($urandom));
            end else begin
                push("Gra Rout MDRin", 5'd0, 1'($urandom));
                repeat (w7) push("Write", 5'd0, 1'b0);
                push("Write", 5'd0, 1'b1);
            end
        end else if (op == 5'd19) begin
            push("Gra Rout CONin", 5'd0, 1'($urandom));
            push("PCout Yin", 5'd0, 1'($urandom));
            push("Cout Zin", 5'd0, 1'($urandom));
            push(con ? "Zlowout PCin" : "", 5'd0, 1'($urandom));
        end else if (op == 5'd20) begin
            push("Gra Rout PCin", 5'd0, 1'($urandom));
        end else if (op == 5'd21) begin
            push("HIout Gra Rin", 5'd0, 1'($urandom));
        end else if (op == 5'd22) begin
            push("LOout Gra Rin", 5'd0, 1'($urandom));
        end else if (op == 5'd24) begin
            halt_pend = 1'b1;
        end else if (op >= 5'd25) begin
            halt_pend = TRAP;
            trap_pend = TRAP;
        end
    endtask

    task automatic run_n(input int n);
        for (int k = 0; k < n; k++) begin
            cur       = q.pop_front();
            mem_ready = cur.mr;
            IR        = cur.ir;
            CON_FF    = cur.con;
            chk_en    = 1'b1;
            @(posedge clock); #1;
        end
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        clear  = 1'b0;
        #1;
        check("reset_strobes", 32'(pack_dut()), 32'd0);
        check("reset_ops", 32'(ops), 32'd0);
        check("reset_illegal", 32'(illegal), 32'd0);
        @(posedge clock); #1;
        clear = 1'b1;
    endtask

    task automatic exec(input logic [4:0] op, input logic con, input int w1, input int w6, input int w7);
        plan(op, con, w1, w6, w7);
        if (halt_pend) begin
            repeat (3) push_ex("", 5'd0, 1'($urandom), 1'b0, trap_pend);
            run_n(q.size());
            do_reset();
            halt_pend = 1'b0;
            trap_pend = 1'b0;
        end else begin
            run_n(q.size());
        end
    endtask

    // Every cycle of a planned instruction, compare all outputs against the plan
    always @(negedge clock) begin
        if (chk_en) begin
            check("strobes", 32'(pack_dut()), 32'(cur.ctl));
            check("ops", 32'(ops), 32'(cur.ops));
            check("run", 32'(run), 32'(cur.run));
            check("illegal", 32'(illegal), 32'(cur.ill));
        end
    end

    initial begin
        n_chk = 0; n_pass = 0; chk_en = 1'b0; irin_cnt = 0;
        halt_pend = 1'b0; trap_pend = 1'b0;
        clear = 1'b0; IR = 32'd0; mem_ready = 1'b0; CON_FF = 1'b0;
        plan_ir = 32'd0; plan_con = 1'b0;
        #1;
        check("reset_strobes0", 32'(pack_dut()), 32'd0);
        check("reset_ops0", 32'(ops), 32'd0);

        // Directed: add with memory always ready, literal expectations
        @(posedge clock); #1;
        clear = 1'b1; mem_ready = 1'b1; IR = {5'b00000, 27'h0123456};
        @(negedge clock); irin_cnt += int'(IRin);
        check("c1_t0", 32'({PCout, MARin, IncPC, Zin, Read}), 32'b11110);
        check("c1_run", 32'(run), 32'd1);
        @(negedge clock); irin_cnt += int'(IRin);
        check("c2_t1", 32'({Zlowout, PCin, Read, MDRin, IRin}), 32'b11110);
        @(negedge clock); irin_cnt += int'(IRin);
        check("c3_t2", 32'({MDRout, IRin, Read}), 32'b110);
        @(negedge clock); irin_cnt += int'(IRin);
        check("add_t3", 32'({Grb, Rout, Yin, Zin}), 32'b1110);
        @(negedge clock); irin_cnt += int'(IRin);
        check("add_t4", 32'({Grc, Rout, Zin, Gra}), 32'b1110);
        check("add_t4_ops", 32'(ops), 32'b00000);
        @(negedge clock); irin_cnt += int'(IRin);
        check("add_t5", 32'({Zlowout, Gra, Rin, Zin}), 32'b1110);
        @(negedge clock); irin_cnt += int'(IRin);
        check("add_next_t0", 32'({PCout, MARin, IncPC, Zin}), 32'b1111);
        check("irin_cycles", 32'(irin_cnt), 32'd1);
        @(posedge clock); #1;
        do_reset();

        // Directed: sub, ld with 3 wait cycles, br not taken/taken, mul, opcode 11111
        exec(5'b00001, 1'b0, 0, 0, 0);
        exec(5'b10001, 1'b0, 1, 3, 0);
        exec(5'b10011, 1'b0, 0, 0, 0);
        exec(5'b10011, 1'b1, 0, 0, 0);
        exec(5'b01111, 1'b0, 0, 0, 0);
        exec(5'b11111, 1'b0, 0, 0, 0);

        // Directed: clear asserted while st waits in T7 with Write high
        plan(5'b10010, 1'b0, 0, 0, 4);
        run_n(8);
        check("st_t7_write", 32'(Write), 32'd1);
        chk_en = 1'b0;
        q.delete();
        clear = 1'b0;
        #1;
        check("st_clear_write", 32'(Write), 32'd0);
        check("st_clear_strobes", 32'(pack_dut()), 32'd0);
        @(posedge clock); #1;
        clear = 1'b1;
        exec(5'b01100, 1'b1, 0, 0, 0);

        // Random instruction stream with random memory latencies
        for (int n = 0; n < 80; n++) begin
            exec(5'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
